ne_rx_ring_ctrl: RTL and testbench

Receive-ring scheduler for the NE2000 emulation. It takes Ethernet frames pushed byte-by-byte by the io controller and places them into the 256-byte-page receive ring of the packet RAM, bounded by PSTART/PSTOP/BNRY. It prepends the DP8390 4-byte receive header, advances CURR, and reports PRX/OVW events for the ISR. It sits between the io-controller rx port and the packet RAM write port; the CPU register file supplies the ring configuration.

---
 rtl/ne_rx_ring_ctrl_if.sv | 17 +
 rtl/ne_rx_ring_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_ne_rx_ring_ctrl.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/ne_rx_ring_ctrl_if.sv
// Receive-side byte stream from the io controller into the ring scheduler.
//   rx_start  1-cycle strobe announcing a new frame
//   rx_len    frame length in bytes, sampled with rx_start
//   rx_valid  rx_data carries a frame byte
//   rx_data   frame byte
//   rx_ready  scheduler accepts rx_data this cycle
// master = io controller, slave = ne_rx_ring_ctrl.
interface ne_rx_ring_ctrl_if;
  logic        rx_start;
  logic [10:0] rx_len;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;

  modport master (output rx_start, rx_len, rx_valid, rx_data, input rx_ready);
  modport slave  (input rx_start, rx_len, rx_valid, rx_data, output rx_ready);
endinterface

// File: rtl/ne_rx_ring_ctrl.sv
// NE2000 receive-ring scheduler. Stores incoming frames into the 256-byte-page
// receive ring (PSTART..PSTOP-1, bounded by BNRY), writes the 4-byte DP8390
// receive header in front of each stored frame, advances CURR, and raises
// PRX / OVW / error pulses for the ISR.
//   clk, reset_n          clock, synchronous active-low reset
//   pstart, pstop, bnry   ring configuration (sampled live)
//   stop                  CR.STP, drops new frames
//   curr_wr, curr_wdata   CPU write of CURR
//   rx                    byte stream from the io controller (slave side)
//   mem_we/addr/wdata     registered packet RAM write port
//   curr                  current page register
//   busy                  frame in progress
//   prx/ovw/err_pulse     one-cycle event pulses
module ne_rx_ring_ctrl #(
  parameter int          FRAME_MAX = 1536,
  parameter logic [7:0]  STATUS_OK = 8'h01
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [7:0]                pstart,
  input  logic [7:0]                pstop,
  input  logic [7:0]                bnry,
  input  logic                      stop,
  input  logic                      curr_wr,
  input  logic [7:0]                curr_wdata,
  ne_rx_ring_ctrl_if.slave          rx,
  output logic                      mem_we,
  output logic [15:0]               mem_addr,
  output logic [7:0]                mem_wdata,
  output logic [7:0]                curr,
  output logic                      busy,
  output logic                      prx_pulse,
  output logic                      ovw_pulse,
  output logic                      err_pulse
);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_DATA, S_HDR, S_DROP, S_DONE
  } state_t;

  localparam logic [10:0] FMAX = 11'(FRAME_MAX);

  state_t      state, state_nx;
  logic [10:0] len;
  logic [10:0] rem;
  logic [15:0] wptr;
  logic [1:0]  hcnt;
  logic [7:0]  pend;
  logic        pend_v;

  logic [15:0] tot_len;
  logic [7:0]  need;
  logic [7:0]  ring;
  logic [7:0]  avail;
  logic [8:0]  nxt9;
  logic [7:0]  next_pg;
  logic [7:0]  wpg_inc;
  logic [15:0] wptr_nx;
  logic        bad;
  logic        no_room;
  logic        rdy;
  logic        accept;
  logic        drop_exit;
  logic [7:0]  hdr_byte;

  always_comb begin
    tot_len = {5'd0, len} + 16'd4;
    // pages occupied by header + frame, rounded up
    need    = {5'd0, tot_len[10:8]} + {7'd0, |tot_len[7:0]};
    ring    = pstop - pstart;
    if (bnry == curr)     avail = ring;
    else if (bnry > curr) avail = bnry - curr;
    else                  avail = ring - (curr - bnry);
    nxt9 = {1'b0, curr} + {1'b0, need};
    if (nxt9 >= {1'b0, pstop}) nxt9 = nxt9 - {1'b0, ring};
    next_pg = nxt9[7:0];

    bad     = stop || (len == 11'd0) || (len > FMAX);
    no_room = (need >= avail);

    wpg_inc = wptr[15:8] + 8'd1;
    if (wptr[7:0] == 8'hFF)
      wptr_nx = {(wpg_inc == pstop) ? pstart : wpg_inc, 8'h00};
    else
      wptr_nx = {wptr[15:8], wptr[7:0] + 8'd1};

    rdy       = (state == S_DATA) || ((state == S_DROP) && (rem != 11'd0));
    accept    = rdy && rx.rx_valid;
    drop_exit = (state == S_DROP) && ((rem == 11'd0) || (accept && rem == 11'd1));

    case (hcnt)
      2'd0:    hdr_byte = STATUS_OK;
      2'd1:    hdr_byte = next_pg;
      2'd2:    hdr_byte = tot_len[7:0];
      default: hdr_byte = tot_len[15:8];
    endcase
  end

  assign rx.rx_ready = rdy;
  assign busy        = (state != S_IDLE);

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (rx.rx_start) state_nx = S_CHECK;
      S_CHECK: state_nx = (bad || no_room) ? S_DROP : S_DATA;
      S_DATA:  if (accept && rem == 11'd1) state_nx = S_HDR;
      S_HDR:   if (hcnt == 2'd3) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      S_DROP:  if (drop_exit) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      len       <= '0;
      rem       <= '0;
      wptr      <= '0;
      hcnt      <= '0;
      pend      <= '0;
      pend_v    <= 1'b0;
      curr      <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      prx_pulse <= 1'b0;
      ovw_pulse <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      state     <= state_nx;
      mem_we    <= 1'b0;
      prx_pulse <= 1'b0;
      ovw_pulse <= 1'b0;
      err_pulse <= 1'b0;

      // CPU writes during a frame are parked and applied on frame exit
      if (curr_wr && state != S_IDLE) begin
        pend   <= curr_wdata;
        pend_v <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (curr_wr) curr <= curr_wdata;
          if (rx.rx_start) begin
            len <= rx.rx_len;
            rem <= rx.rx_len;
          end
        end
        S_CHECK: begin
          wptr      <= {curr, 8'h04};
          hcnt      <= '0;
          err_pulse <= bad;
          ovw_pulse <= !bad && no_room;
        end
        S_DATA: begin
          if (accept) begin
            mem_we    <= 1'b1;
            mem_addr  <= wptr;
            mem_wdata <= rx.rx_data;
            rem       <= rem - 11'd1;
            wptr      <= wptr_nx;
          end
        end
        S_HDR: begin
          mem_we    <= 1'b1;
          mem_addr  <= {curr, 6'd0, hcnt};
          mem_wdata <= hdr_byte;
          hcnt      <= hcnt + 2'd1;
        end
        S_DONE: begin
          prx_pulse <= 1'b1;
          pend_v    <= 1'b0;
          if (curr_wr)     curr <= curr_wdata;
          else if (pend_v) curr <= pend;
          else             curr <= next_pg;
        end
        S_DROP: begin
          if (accept) rem <= rem - 11'd1;
          if (drop_exit) begin
            pend_v <= 1'b0;
            if (curr_wr)     curr <= curr_wdata;
            else if (pend_v) curr <= pend;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ne_rx_ring_ctrl.sv
module tb_ne_rx_ring_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  pstart, pstop, bnry;
  logic        stop;
  logic        curr_wr;
  logic [7:0]  curr_wdata;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  curr;
  logic        busy, prx_pulse, ovw_pulse, err_pulse;

  ne_rx_ring_ctrl_if rxif ();

  ne_rx_ring_ctrl #(.FRAME_MAX(1536), .STATUS_OK(8'h01)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pstart     (pstart),
    .pstop      (pstop),
    .bnry       (bnry),
    .stop       (stop),
    .curr_wr    (curr_wr),
    .curr_wdata (curr_wdata),
    .rx         (rxif),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .curr       (curr),
    .busy       (busy),
    .prx_pulse  (prx_pulse),
    .ovw_pulse  (ovw_pulse),
    .err_pulse  (err_pulse)
  );

  always #5 clk = ~clk;

  // write log: every RAM write in order
  logic [15:0] wl_a [8192];
  logic [7:0]  wl_d [8192];
  int          wcnt = 0;
  always @(posedge clk) begin
    if (mem_we) begin
      wl_a[wcnt % 8192] <= mem_addr;
      wl_d[wcnt % 8192] <= mem_wdata;
      wcnt <= wcnt + 1;
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // res: 0 = stored (prx), 1 = overflow (ovw), 2 = bad length / stop (err)
  typedef struct {
    logic [7:0]  ps, pe, bn, cu;
    logic        st;
    int          len;
    int          res;
    logic [7:0]  exp_next;
    logic [15:0] exp_lenw;
  } vec_t;

  vec_t vt [12];

  task automatic load_curr(input logic [7:0] v);
    curr_wr = 1'b1; curr_wdata = v;
    @(posedge clk); #1;
    curr_wr = 1'b0;
  endtask

  task automatic run_frame(input vec_t v, input bit bp, input int cwr_at,
                           input logic [7:0] cwr_val, input string tag);
    int cyc, acc, first, nprx, novw, nerr, base, lim, errs;
    bit done, cwr_done, take;
    logic [7:0] pg, off;
    logic [15:0] ea;
    pstart = v.ps; pstop = v.pe; bnry = v.bn; stop = v.st;
    load_curr(v.cu);
    base = wcnt;
    rxif.rx_start = 1'b1; rxif.rx_len = 11'(v.len);
    @(posedge clk); #1;
    rxif.rx_start = 1'b0;
    cyc = 1; acc = 0; first = -1; nprx = 0; novw = 0; nerr = 0;
    done = 0; cwr_done = 0;
    lim = v.len * 3 + 50;
    while (!done && cyc < lim) begin
      nprx += int'(prx_pulse); novw += int'(ovw_pulse); nerr += int'(err_pulse);
      if (!busy) done = 1;
      else begin
        rxif.rx_valid = bp ? cyc[0] : 1'b1;
        rxif.rx_data  = 8'(acc);
        if (cwr_at >= 0 && acc == cwr_at && !cwr_done) begin
          curr_wr = 1'b1; curr_wdata = cwr_val; cwr_done = 1;
        end
        if (rxif.rx_ready && first < 0) first = cyc;
        take = rxif.rx_ready && rxif.rx_valid;
        @(posedge clk); #1;
        curr_wr = 1'b0;
        if (take) acc++;
        cyc++;
      end
    end
    rxif.rx_valid = 1'b0;
    stop = 1'b0;
    chk({tag, ".finish"}, 32'(done), 32'd1);
    chk({tag, ".prx"}, 32'(nprx), (v.res == 0) ? 32'd1 : 32'd0);
    chk({tag, ".ovw"}, 32'(novw), (v.res == 1) ? 32'd1 : 32'd0);
    chk({tag, ".err"}, 32'(nerr), (v.res == 2) ? 32'd1 : 32'd0);
    chk({tag, ".curr"}, 32'(curr),
        (cwr_at >= 0) ? 32'(cwr_val) : ((v.res == 0) ? 32'(v.exp_next) : 32'(v.cu)));
    chk({tag, ".accepted"}, 32'(acc), 32'(v.len));
    chk({tag, ".writes"}, 32'(wcnt - base), (v.res == 0) ? 32'(v.len + 4) : 32'd0);
    if (v.len > 0) chk({tag, ".rdy_lat"}, 32'(first), 32'd2);
    if (v.res == 0) begin
      errs = 0;
      pg = v.cu; off = 8'h04;
      for (int i = 0; i < v.len; i++) begin
        ea = {pg, off};
        if (wl_a[(base + i) % 8192] !== ea || wl_d[(base + i) % 8192] !== 8'(i)) errs++;
        if (off == 8'hFF) begin
          pg = pg + 8'd1;
          if (pg == v.pe) pg = v.ps;
        end
        off = off + 8'd1;
      end
      chk({tag, ".data"}, 32'(errs), 32'd0);
      errs = 0;
      for (int unsigned h = 0; h < 4; h++)
        if (wl_a[(base + v.len + int'(h)) % 8192] !== {v.cu, 8'(h)}) errs++;
      chk({tag, ".hdr_addr"}, 32'(errs), 32'd0);
      chk({tag, ".hdr_data"},
          {wl_d[(base + v.len) % 8192], wl_d[(base + v.len + 1) % 8192],
           wl_d[(base + v.len + 2) % 8192], wl_d[(base + v.len + 3) % 8192]},
          {8'h01, v.exp_next, v.exp_lenw[7:0], v.exp_lenw[15:8]});
    end
  endtask

  initial begin
    int acc, nprx, cyc;
    bit hit;
    vt[0]  = '{8'h4C, 8'h80, 8'h4C, 8'h4C, 1'b0,   60, 0, 8'h4D, 16'h0040};
    vt[1]  = '{8'h4C, 8'h80, 8'h50, 8'h7F, 1'b0,  300, 0, 8'h4D, 16'h0130};
    vt[2]  = '{8'h4C, 8'h80, 8'h50, 8'h4F, 1'b0,   60, 1, 8'h00, 16'h0000};
    vt[3]  = '{8'h4C, 8'h80, 8'h4C, 8'h4C, 1'b0, 1537, 2, 8'h00, 16'h0000};
    vt[4]  = '{8'h4C, 8'h80, 8'h4C, 8'h4C, 1'b1,   64, 2, 8'h00, 16'h0000};
    vt[5]  = '{8'h4C, 8'h80, 8'h4C, 8'h4C, 1'b0,    0, 2, 8'h00, 16'h0000};
    vt[6]  = '{8'h4C, 8'h80, 8'h4C, 8'h4C, 1'b0, 1536, 0, 8'h53, 16'h0604};
    vt[7]  = '{8'h4C, 8'h80, 8'h4C, 8'h4C, 1'b0,  252, 0, 8'h4D, 16'h0100};
    vt[8]  = '{8'h4C, 8'h80, 8'h4C, 8'h4C, 1'b0,  253, 0, 8'h4E, 16'h0101};
    vt[9]  = '{8'h4C, 8'h80, 8'h52, 8'h50, 1'b0,  252, 0, 8'h51, 16'h0100};
    vt[10] = '{8'h4C, 8'h80, 8'h52, 8'h50, 1'b0,  253, 1, 8'h00, 16'h0000};
    vt[11] = '{8'h4C, 8'h80, 8'h7F, 8'h7F, 1'b0,   60, 0, 8'h4C, 16'h0040};

    reset_n = 1'b0; pstart = 8'h4C; pstop = 8'h80; bnry = 8'h4C; stop = 1'b0;
    curr_wr = 1'b0; curr_wdata = '0;
    rxif.rx_start = 1'b0; rxif.rx_len = '0; rxif.rx_valid = 1'b0; rxif.rx_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.curr", 32'(curr), 32'h00);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.rx_ready", 32'(rxif.rx_ready), 32'd0);
    chk("rst.mem", {15'd0, mem_we, mem_addr[7:0], mem_wdata}, 32'd0);
    chk("rst.pulses", {prx_pulse, ovw_pulse, err_pulse}, 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    load_curr(8'h5A);
    chk("idle.curr_load", 32'(curr), 32'h5A);

    for (int unsigned i = 0; i < 12; i++)
      run_frame(vt[i], 1'b0, -1, 8'h00, $sformatf("vec%0d", i));

    // rx_valid toggling: contiguous writes, no duplicates
    run_frame(vt[0], 1'b1, -1, 8'h00, "backpressure");
    // CPU write mid-DATA overrides computed next page
    run_frame(vt[0], 1'b0, 10, 8'h60, "curr_wr_mid");
    // CPU write during a dropped frame is applied on exit
    run_frame(vt[2], 1'b0, 5, 8'h55, "curr_wr_drop");

    // reset during byte 20 of a 100-byte frame
    pstart = 8'h4C; pstop = 8'h80; bnry = 8'h4C;
    load_curr(8'h4C);
    rxif.rx_start = 1'b1; rxif.rx_len = 11'd100;
    @(posedge clk); #1;
    rxif.rx_start = 1'b0;
    acc = 0; hit = 0; cyc = 0;
    while (!hit && cyc < 200) begin
      rxif.rx_valid = 1'b1; rxif.rx_data = 8'(acc);
      if (rxif.rx_ready && acc == 20) begin
        reset_n = 1'b0; hit = 1;
      end
      if (rxif.rx_ready) acc++;
      @(posedge clk); #1;
      cyc++;
    end
    chk("rstmid.reached", 32'(hit), 32'd1);
    chk("rstmid.curr", 32'(curr), 32'h00);
    chk("rstmid.busy", 32'(busy), 32'd0);
    chk("rstmid.rx_ready", 32'(rxif.rx_ready), 32'd0);
    chk("rstmid.mem", {15'd0, mem_we, mem_addr[7:0], mem_wdata}, 32'd0);
    chk("rstmid.mem_addr_hi", 32'(mem_addr[15:8]), 32'd0);
    chk("rstmid.pulses", {prx_pulse, ovw_pulse, err_pulse}, 32'd0);
    reset_n = 1'b1;
    rxif.rx_valid = 1'b0;
    nprx = 0;
    repeat (10) begin
      @(posedge clk); #1;
      nprx += int'(prx_pulse);
    end
    chk("rstmid.no_prx", 32'(nprx), 32'd0);
    chk("rstmid.idle", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
